// File: rtl/shifter_serial.sv
// Bit-serial ARM barrel-shifter replacement: one shift step per clock.
// Supports LSL/LSR/ASR/ROR/RRX with register or immediate amount encodings.
module shifter_serial (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  shift_type,
    input  logic        is_imm,
    input  logic [7:0]  amount,
    input  logic [31:0] operand,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_LSR = 3'd1,
        OP_ASR = 3'd2,
        OP_ROR = 3'd3,
        OP_RRX = 3'd4
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [5:0] n;
    } plan_t;

    // Decode the request into a per-step operation and a step count.
    function automatic plan_t plan_request(input logic [1:0] st, input logic imm,
                                           input logic [7:0] amt);
        plan_t      p;
        logic [4:0] a;
        a    = amt[4:0];
        p.op = OP_LSL;
        p.n  = 6'd0;
        if (imm) begin
            case (st)
                2'b00: begin p.op = OP_LSL; p.n = {1'b0, a}; end
                2'b01: begin p.op = OP_LSR; p.n = (a == 5'd0) ? 6'd32 : {1'b0, a}; end
                2'b10: begin p.op = OP_ASR; p.n = (a == 5'd0) ? 6'd32 : {1'b0, a}; end
                2'b11: begin
                    if (a == 5'd0) begin
                        p.op = OP_RRX;
                        p.n  = 6'd1;
                    end else begin
                        p.op = OP_ROR;
                        p.n  = {1'b0, a};
                    end
                end
                default: ;
            endcase
        end else begin
            case (st)
                2'b00: begin p.op = OP_LSL; p.n = (amt > 8'd33) ? 6'd33 : amt[5:0]; end
                2'b01: begin p.op = OP_LSR; p.n = (amt > 8'd33) ? 6'd33 : amt[5:0]; end
                2'b10: begin p.op = OP_ASR; p.n = (amt > 8'd32) ? 6'd32 : amt[5:0]; end
                2'b11: begin
                    p.op = OP_ROR;
                    if (amt == 8'd0)
                        p.n = 6'd0;
                    else if (a == 5'd0)
                        p.n = 6'd32;
                    else
                        p.n = {1'b0, a};
                end
                default: ;
            endcase
        end
        return p;
    endfunction

    // One serial step; returns {carry, value}.
    function automatic logic [32:0] shift_step(input op_e op, input logic [31:0] r,
                                               input logic c);
        logic [32:0] y;
        case (op)
            OP_LSL:  y = {r[31], r[30:0], 1'b0};
            OP_LSR:  y = {r[0], 1'b0, r[31:1]};
            OP_ASR:  y = {r[0], r[31], r[31:1]};
            OP_ROR:  y = {r[0], r[0], r[31:1]};
            OP_RRX:  y = {r[0], c, r[31:1]};
            default: y = {c, r};
        endcase
        return y;
    endfunction

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    plan_t       plan;

    assign plan = plan_request(shift_type, is_imm, amount);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        result_d = result_q;
        carry_d  = carry_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    result_d = operand;
                    carry_d  = carry_in;
                    op_d     = plan.op;
                    count_d  = plan.n;
                    state_d  = (plan.n == 6'd0) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                {carry_d, result_d} = shift_step(op_q, result_q, carry_q);
                count_d = count_q - 6'd1;
                if (count_q <= 6'd1)
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so rst_n is just another input sampled at the edge.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LSL;
            count_q  <= 6'd0;
            result_q <= 32'd0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_shifter_serial.sv
// Self-checking bench for shifter_serial: vector table plus multi-cycle
// sequences (ignored start, back-to-back, mid-operation reset).
module tb_shifter_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  shift_type;
    logic        is_imm;
    logic [7:0]  amount;
    logic [31:0] operand;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;

    shifter_serial dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .shift_type (shift_type),
        .is_imm     (is_imm),
        .amount     (amount),
        .operand    (operand),
        .carry_in   (carry_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_out  (carry_out)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;

    typedef struct {
        logic [1:0]  st;
        logic        imm;
        logic [7:0]  amt;
        logic [31:0] opnd;
        logic        cin;
        logic [31:0] res;
        logic        cout;
        int          n;
    } vec_t;

    vec_t vecs[19];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [1:0] st, input logic imm, input logic [7:0] amt,
                                input logic [31:0] opnd, input logic cin,
                                input logic [31:0] res, input logic cout, input int n);
        vec_t v;
        v.st = st; v.imm = imm; v.amt = amt; v.opnd = opnd; v.cin = cin;
        v.res = res; v.cout = cout; v.n = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v, input bit push);
        shift_type = v.st;
        is_imm     = v.imm;
        amount     = v.amt;
        operand    = v.opnd;
        carry_in   = v.cin;
        start      = 1'b1;
        if (push) sb.push_back(v);
    endtask

    task automatic scramble_inputs();
        shift_type = 2'($urandom);
        is_imm     = 1'($urandom);
        amount     = 8'($urandom);
        operand    = $urandom;
        carry_in   = 1'($urandom);
    endtask

    // Called at #1 after the accepting edge; counts edges until done shows up.
    task automatic wait_done(output int lat, output int busy_cycles, input int pulse_at);
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
            if (pulse_at >= 0) begin
                start = (lat == pulse_at);
                if (start) scramble_inputs();
            end
        end
    endtask

    task automatic finish_op(input string name, input bit check_idle, input int pulse_at);
        int   lat, bc;
        vec_t e;
        wait_done(lat, bc, pulse_at);
        check({name, " done_seen"}, 32'(done), 32'd1);
        if (sb.size() == 0) begin
            check({name, " scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, " result"}, result, e.res);
            check({name, " carry"}, 32'(carry_out), 32'(e.cout));
            check({name, " latency"}, 32'(lat), 32'(e.n));
            check({name, " busy_cycles"}, 32'(bc), 32'(e.n));
        end
        if (check_idle) begin
            @(posedge clk);
            #1;
            check({name, " done_drops"}, 32'(done), 32'd0);
            check({name, " busy_idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(LSL, 0, 8'd4,    32'h0000_00F1, 0, 32'h0000_0F10, 0, 4);
        vecs[1]  = mk(LSR, 1, 8'd0,    32'h8000_0000, 0, 32'h0000_0000, 1, 32);
        vecs[2]  = mk(LSL, 0, 8'd33,   32'hFFFF_FFFF, 0, 32'h0000_0000, 0, 33);
        vecs[3]  = mk(ASR, 0, 8'd40,   32'h8000_0001, 0, 32'hFFFF_FFFF, 1, 32);
        vecs[4]  = mk(ROR, 1, 8'd0,    32'h0000_0003, 1, 32'h8000_0001, 1, 1);
        vecs[5]  = mk(ROR, 0, 8'd32,   32'h8000_0000, 0, 32'h8000_0000, 1, 32);
        vecs[6]  = mk(LSL, 0, 8'd0,    32'h1234_5678, 1, 32'h1234_5678, 1, 0);
        vecs[7]  = mk(LSR, 0, 8'd8,    32'h1234_5678, 0, 32'h0012_3456, 0, 8);
        vecs[8]  = mk(ASR, 1, 8'd4,    32'hF000_0018, 0, 32'hFF00_0001, 1, 4);
        vecs[9]  = mk(ROR, 1, 8'd8,    32'h1234_5678, 1, 32'h7812_3456, 0, 8);
        vecs[10] = mk(LSL, 1, 8'd1,    32'h8000_0001, 0, 32'h0000_0002, 1, 1);
        vecs[11] = mk(LSR, 0, 8'd32,   32'hA5A5_A5A5, 0, 32'h0000_0000, 1, 32);
        vecs[12] = mk(ROR, 0, 8'd0,    32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0);
        vecs[13] = mk(ROR, 0, 8'd36,   32'h0000_000F, 0, 32'hF000_0000, 1, 4);
        vecs[14] = mk(LSL, 0, 8'd200,  32'h0000_0001, 1, 32'h0000_0000, 0, 33);
        vecs[15] = mk(ASR, 0, 8'd5,    32'h7FFF_FFFF, 0, 32'h03FF_FFFF, 1, 5);
        vecs[16] = mk(LSR, 1, 8'd31,   32'h8000_0000, 1, 32'h0000_0001, 0, 31);
        vecs[17] = mk(ROR, 1, 8'h20,   32'h0000_0002, 0, 32'h0000_0001, 0, 1);
        vecs[18] = mk(LSL, 1, 8'h25,   32'h0800_0001, 0, 32'h0000_0020, 1, 5);

        rst_n = 1'b0;
        start = 1'b0;
        shift_type = 2'b00; is_imm = 1'b0; amount = 8'd0; operand = 32'd0; carry_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset carry", 32'(carry_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive_req(vecs[i], 1'b1);
            @(posedge clk);
            #1;
            start = 1'b0;
            scramble_inputs();
            finish_op($sformatf("vec%0d", i), 1'b1, -1);
        end

        // start pulsed mid-SHIFT must be ignored
        @(negedge clk);
        drive_req(mk(LSR, 0, 8'd8, 32'h1234_5678, 0, 32'h0012_3456, 0, 8), 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_op("ignore_start", 1'b1, 3);

        // start held high through DONE: second request follows back-to-back
        @(negedge clk);
        drive_req(mk(LSL, 0, 8'd2, 32'h0000_0001, 0, 32'h0000_0004, 0, 2), 1'b1);
        @(posedge clk);
        #1;
        drive_req(mk(LSR, 0, 8'd1, 32'h0000_0005, 0, 32'h0000_0002, 1, 1), 1'b1);
        finish_op("b2b_first", 1'b0, -1);
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();
        check("b2b accepted busy", 32'(busy), 32'd1);
        check("b2b accepted done", 32'(done), 32'd0);
        finish_op("b2b_second", 1'b1, -1);

        // reset in the middle of a 20-step LSR aborts it
        @(negedge clk);
        drive_req(mk(LSR, 0, 8'd20, 32'hFFFF_FFFF, 0, 32'h0000_0FFF, 1, 20), 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst carry", 32'(carry_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_req(mk(LSR, 0, 8'd3, 32'h0000_0014, 0, 32'h0000_0002, 1, 3), 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("post_rst accepted", 32'(busy), 32'd1);
        finish_op("post_rst", 1'b1, -1);

        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) check("late done", 32'(done), 32'd0);
        end
        check("final idle done", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
